// File: rtl/geofence_pkg.sv
// geofence_pkg: state encoding and width helpers shared by the geofence blocks
package geofence_pkg;
   localparam logic [2:0] S_LOAD   = 3'd0;
   localparam logic [2:0] S_SORT   = 3'd1;
   localparam logic [2:0] S_PLACE  = 3'd2;
   localparam logic [2:0] S_TEST   = 3'd3;
   localparam logic [2:0] S_RESULT = 3'd4;
   function automatic int diff_w(input int cw);
      return cw + 1;
   endfunction
   function automatic int prod_w(input int cw);
      return 2 * cw + 2;
   endfunction
   function automatic int idx_w(input int n);
      return $clog2(n + 2);
   endfunction
   function automatic int rank_w(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/geofence_cross.sv
// geofence_cross: one signed product (a0-a1)*(b0-b1) per cycle, shared by sort and test
module geofence_cross
   import geofence_pkg::*;
#(
   parameter int CW = 10
) (
   input  logic [CW-1:0]                a0,
   input  logic [CW-1:0]                a1,
   input  logic [CW-1:0]                b0,
   input  logic [CW-1:0]                b1,
   output logic signed [prod_w(CW)-1:0] prod
);
   localparam int DW = diff_w(CW);
   localparam int PW = prod_w(CW);
   logic signed [DW-1:0] da, db;
   // differences are exact in CW+1 bits, the product is sign-extended to full width
   always_comb begin
      da = $signed(DW'(a0) - DW'(a1));
      db = $signed(DW'(b0) - DW'(b1));
      prod = PW'(da) * PW'(db);
   end
endmodule

// File: rtl/geofence_n.sv
// geofence_n: point-in-convex-polygon test with angular vertex sort on a shared multiplier
module geofence_n
   import geofence_pkg::*;
#(
   parameter int N_VERT       = 6,
   parameter int CW           = 10,
   parameter int INCLUDE_EDGE = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] X,
   input  logic [CW-1:0] Y,
   input  logic          in_valid,
   output logic          ready,
   output logic          valid,
   output logic          is_inside,
   output logic          on_edge
);
   localparam int PW = prod_w(CW);
   localparam int IW = idx_w(N_VERT);
   localparam int RW = rank_w(N_VERT);
   localparam int NA = 1 << IW;
   localparam logic [IW-1:0] LASTV = IW'(N_VERT - 1);
   localparam logic [IW-1:0] NV = IW'(N_VERT);
   logic [2:0]            state;
   logic [IW-1:0]         cnt, sk, sj, ti, tb;
   logic                  ph, tst, strict, bound;
   logic [CW-1:0]         px, py, a0, a1, b0, b1;
   logic [CW-1:0]         vx [NA];
   logic [CW-1:0]         vy [NA];
   logic [CW-1:0]         sx [NA];
   logic [CW-1:0]         sy [NA];
   logic [RW-1:0]         rank [NA];
   logic signed [PW-1:0]  p1, prod;
   logic                  any_pos, any_neg, any_zero;
   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] j, input logic [IW-1:0] k);
      return (j + IW'(1) == k) ? j + IW'(2) : j + IW'(1);
   endfunction
   assign ready = (state == S_LOAD) && !reset;
   geofence_cross #(.CW(CW)) u_cross (
      .a0  (a0),
      .a1  (a1),
      .b0  (b0),
      .b1  (b1),
      .prod(prod)
   );
   // operand steering: sort compares vk against vj around v0, test walks sorted edges against P
   always_comb begin
      tst = state == S_TEST;
      tb = (ti == LASTV) ? '0 : ti + IW'(1);
      a0 = tst ? (ph ? sx[tb] : sx[ti]) : (ph ? vx[sj] : vx[sk]);
      a1 = tst ? (ph ? sx[ti] : px) : vx[0];
      b0 = tst ? (ph ? sy[ti] : sy[tb]) : (ph ? vy[sk] : vy[sj]);
      b1 = tst ? (ph ? py : sy[ti]) : vy[0];
      strict = !any_zero && !(any_pos && any_neg);
      bound = any_zero && !(any_pos && any_neg);
   end
   // control sequence and datapath registers; outputs strobe on leaving RESULT
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_LOAD;
         cnt <= '0;
         valid <= 1'b0;
         is_inside <= 1'b0;
         on_edge <= 1'b0;
      end else begin
         valid <= state == S_RESULT;
         is_inside <= (state == S_RESULT) && (strict || ((INCLUDE_EDGE != 0) && bound));
         on_edge <= (state == S_RESULT) && bound;
         case (state)
            S_LOAD: if (in_valid) begin
               if (cnt == '0) begin
                  px <= X;
                  py <= Y;
               end else begin
                  vx[cnt - IW'(1)] <= X;
                  vy[cnt - IW'(1)] <= Y;
               end
               if (cnt == NV) begin
                  cnt <= '0;
                  state <= S_SORT;
                  sk <= IW'(1);
                  sj <= IW'(2);
                  ph <= 1'b0;
                  for (int i = 0; i < NA; i++) rank[IW'(i)] <= '0;
               end else begin
                  cnt <= cnt + IW'(1);
               end
            end
            S_SORT: begin
               ph <= ~ph;
               if (!ph) begin
                  p1 <= prod;
               end else begin
                  if (p1 < prod) rank[sk] <= rank[sk] + RW'(1);
                  if (nxt(sj, sk) > LASTV) begin
                     if (sk == LASTV) state <= S_PLACE;
                     sk <= sk + IW'(1);
                     sj <= IW'(1);
                  end else begin
                     sj <= nxt(sj, sk);
                  end
               end
            end
            S_PLACE: begin
               sx[0] <= vx[0];
               sy[0] <= vy[0];
               for (int k = 1; k < N_VERT; k++) begin
                  sx[IW'(rank[IW'(k)]) + IW'(1)] <= vx[IW'(k)];
                  sy[IW'(rank[IW'(k)]) + IW'(1)] <= vy[IW'(k)];
               end
               ti <= '0;
               ph <= 1'b0;
               any_pos <= 1'b0;
               any_neg <= 1'b0;
               any_zero <= 1'b0;
               state <= S_TEST;
            end
            S_TEST: begin
               ph <= ~ph;
               if (!ph) begin
                  p1 <= prod;
               end else begin
                  if (p1 > prod) any_pos <= 1'b1;
                  if (p1 < prod) any_neg <= 1'b1;
                  if (p1 == prod) any_zero <= 1'b1;
                  if (ti == LASTV) state <= S_RESULT;
                  ti <= ti + IW'(1);
               end
            end
            S_RESULT: state <= S_LOAD;
            default: state <= S_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_geofence_n.sv
// tb_geofence_n: table-driven scoreboard bench for geofence_n (hexagon, edge-inclusive hexagon, triangle)
module tb_geofence_n;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   logic [9:0] x6 = '0, y6 = '0, x3 = '0, y3 = '0;
   logic iv6 = 1'b0, iv3 = 1'b0;
   logic r6, v6, i6, e6, r6e, v6e, i6e, e6e, r3, v3, i3, e3;
   geofence_n #(.N_VERT(6), .CW(10), .INCLUDE_EDGE(0)) u6 (
      .clk(clk), .reset(reset), .X(x6), .Y(y6), .in_valid(iv6),
      .ready(r6), .valid(v6), .is_inside(i6), .on_edge(e6));
   geofence_n #(.N_VERT(6), .CW(10), .INCLUDE_EDGE(1)) u6e (
      .clk(clk), .reset(reset), .X(x6), .Y(y6), .in_valid(iv6),
      .ready(r6e), .valid(v6e), .is_inside(i6e), .on_edge(e6e));
   geofence_n #(.N_VERT(3), .CW(10), .INCLUDE_EDGE(0)) u3 (
      .clk(clk), .reset(reset), .X(x3), .Y(y3), .in_valid(iv3),
      .ready(r3), .valid(v3), .is_inside(i3), .on_edge(e3));
   typedef struct {int px; int py; int ord; bit ins; bit edg;} vec_t;
   typedef struct {bit ins; bit edg; bit inse; int due;} exp_t;
   vec_t vecs[13];
   vec_t tvec[5];
   int ox[3][6], oy[3][6], tx[2][3], ty[2][3];
   exp_t q6[$], q3[$];
   exp_t ex6, ex3;
   int cmp = 0, err = 0, cyc = 0;
   bit mon = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input int act, input int req);
      cmp++;
      if (act != req) begin
         err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask
   // scoreboard monitor at negedge: pops on valid, flags overdue or unexpected results
   always @(negedge clk) if (mon) begin
      if (q6.size() > 0 && cyc > q6[0].due) begin
         chk("lat6_missing", cyc, q6[0].due);
         void'(q6.pop_front());
      end
      if (v6) begin
         if (q6.size() == 0) chk("unexpected_valid6", v6, 0);
         else begin
            ex6 = q6.pop_front();
            chk("lat6", cyc, ex6.due);
            chk("ins6", i6, ex6.ins);
            chk("edge6", e6, ex6.edg);
            chk("valid6e", v6e, 1);
            chk("ins6e", i6e, ex6.inse);
            chk("edge6e", e6e, ex6.edg);
         end
      end else chk("idle6", {v6e, i6, e6, i6e, e6e}, 0);
      if (q3.size() > 0 && cyc > q3[0].due) begin
         chk("lat3_missing", cyc, q3[0].due);
         void'(q3.pop_front());
      end
      if (v3) begin
         if (q3.size() == 0) chk("unexpected_valid3", v3, 0);
         else begin
            ex3 = q3.pop_front();
            chk("lat3", cyc, ex3.due);
            chk("ins3", i3, ex3.ins);
            chk("edge3", e3, ex3.edg);
         end
      end else chk("idle3", {i3, e3}, 0);
   end
   task automatic send(input int d, input int x, input int y);
      int n = 0;
      while (((d == 3) ? r3 : r6) !== 1'b1 && n < 300) begin
         if (d == 3) iv3 = 1'($urandom_range(0, 1));
         else iv6 = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      cmp++;
      if (n >= 300) begin
         err++;
         $display("FAIL ready_timeout: waited %0d cycles, required under 300", n);
      end
      if (d == 3) begin
         x3 = 10'(x);
         y3 = 10'(y);
         iv3 = 1'b1;
      end else begin
         x6 = 10'(x);
         y6 = 10'(y);
         iv6 = 1'b1;
      end
      @(negedge clk);
   endtask
   task automatic set6(input int px, input int py, input int ord, input bit ins, input bit edg, input bit push);
      send(6, px, py);
      for (int k = 0; k < 6; k++) send(6, ox[ord][k], oy[ord][k]);
      if (push) q6.push_back('{ins, edg, ins | edg, cyc + 54});
   endtask
   task automatic set3(input int px, input int py, input int ord, input bit ins, input bit edg);
      send(3, px, py);
      for (int k = 0; k < 3; k++) send(3, tx[ord][k], ty[ord][k]);
      q3.push_back('{ins, edg, ins | edg, cyc + 12});
   endtask
   task automatic wait_idle();
      int n = 0;
      iv6 = 1'b0;
      iv3 = 1'b0;
      while ((q6.size() > 0 || q3.size() > 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask
   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_ready_in_reset"}, r6, 0);
      chk({tag, "_valid_in_reset"}, v6, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk({tag, "_ready_after"}, r6, 1);
   endtask
   initial begin
      ox = '{'{6, 2, 0, 8, 2, 6}, '{0, 2, 6, 8, 6, 2}, '{2, 8, 6, 0, 6, 2}};
      oy = '{'{8, 0, 4, 4, 8, 0}, '{4, 0, 0, 4, 8, 8}, '{8, 4, 0, 4, 8, 0}};
      tx = '{'{0, 1023, 0}, '{0, 1023, 0}};
      ty = '{'{0, 0, 1023}, '{1023, 0, 0}};
      vecs = '{'{4, 4, 0, 1, 0}, '{9, 4, 0, 0, 0}, '{4, 0, 0, 0, 1}, '{1, 4, 1, 1, 0},
               '{0, 4, 2, 0, 1}, '{7, 6, 1, 0, 1}, '{7, 7, 2, 0, 0}, '{4, 8, 2, 0, 1},
               '{4, 9, 1, 0, 0}, '{1, 1, 0, 0, 0}, '{2, 2, 1, 1, 0}, '{7, 2, 2, 0, 1},
               '{6, 7, 0, 1, 0}};
      tvec = '{'{511, 511, 0, 1, 0}, '{1023, 1023, 1, 0, 0}, '{0, 500, 1, 0, 1},
               '{512, 511, 0, 0, 1}, '{600, 600, 0, 0, 0}};
      repeat (3) @(negedge clk);
      chk("rst_ready6", r6, 0);
      chk("rst_ready3", r3, 0);
      chk("rst_valid6", v6, 0);
      chk("rst_outs6", {i6, e6, i6e, e6e}, 0);
      chk("rst_valid3", v3, 0);
      reset = 1'b0;
      mon = 1'b1;
      #1;
      chk("ready_after_rst", r6, 1);
      @(negedge clk);
      foreach (vecs[i]) set6(vecs[i].px, vecs[i].py, vecs[i].ord, vecs[i].ins, vecs[i].edg, 1'b1);
      wait_idle();
      set6(4, 4, 0, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      pulse_reset("abort_sort");
      set6(4, 4, 0, 1'b1, 1'b0, 1'b1);
      wait_idle();
      send(6, 9, 4);
      send(6, 6, 8);
      send(6, 2, 0);
      pulse_reset("abort_load");
      set6(4, 4, 2, 1'b1, 1'b0, 1'b1);
      wait_idle();
      set6(4, 4, 0, 1'b1, 1'b0, 1'b1);
      set6(9, 4, 0, 1'b0, 1'b0, 1'b1);
      wait_idle();
      foreach (tvec[i]) set3(tvec[i].px, tvec[i].py, tvec[i].ord, tvec[i].ins, tvec[i].edg);
      wait_idle();
      repeat (4) @(negedge clk);
      chk("pending_results", q6.size() + q3.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
